// File: rtl/life_pkg.sv
// life_pkg: shared state type, default life/timing constants and the HUD thermometer encoder
package life_pkg;

   typedef enum logic [2:0] {IDLE, ALIVE, DYING, RESPAWN, GAME_OVER} life_state_t;

   localparam int LIFE_INIT_LIVES     = 3;
   localparam int LIFE_MAX_LIVES      = 5;
   localparam int LIFE_DEATH_FRAMES   = 60;
   localparam int LIFE_RESPAWN_FRAMES = 30;

   function automatic logic [31:0] lives_to_mask(input int unsigned n);
      logic [31:0] m;
      for (int unsigned i = 0; i < 32; i++) m[i] = i < n;
      return m;
   endfunction

endpackage

// File: rtl/player_life_ctrl_frame_timer.sv
// frame_timer: counts frame ticks since the last clear and flags the limit-th one
module frame_timer #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         tick,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] cnt_q, cnt_d;

   // clear wins over a coincident tick; expire looks at the tick that would reach the limit
   always_comb begin
      cnt_d  = clear ? '0 : tick ? cnt_q + W'(1) : cnt_q;
      expire = tick && (cnt_q + W'(1) == limit);
   end

   // tick counter register
   always_ff @(posedge clk or posedge reset)
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;

endmodule

// File: rtl/player_life_ctrl.sv
// player_life_ctrl: player life-cycle sequencer owning lives, death/respawn intervals and game over
module player_life_ctrl
   import life_pkg::*;
#(
   parameter int INIT_LIVES     = LIFE_INIT_LIVES,
   parameter int MAX_LIVES      = LIFE_MAX_LIVES,
   parameter int DEATH_FRAMES   = LIFE_DEATH_FRAMES,
   parameter int RESPAWN_FRAMES = LIFE_RESPAWN_FRAMES
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           startOfFrame,
   input  logic                           playGame,
   input  logic                           player_hit,
   input  logic                           bonus_life,
   output logic [$clog2(MAX_LIVES+1)-1:0] lives_count,
   output logic [MAX_LIVES-1:0]           lives_mask,
   output logic                           freeze_game,
   output logic                           player_visible,
   output logic                           death_anim,
   output logic                           respawn,
   output logic                           game_over
);

   localparam int LW = $clog2(MAX_LIVES + 1);
   localparam int TW = $clog2((DEATH_FRAMES > RESPAWN_FRAMES ? DEATH_FRAMES : RESPAWN_FRAMES) + 1);

   life_state_t          state_q, state_d;
   logic [LW-1:0]        lives_q, lives_d, lives_up, lives_dn, lives_b;
   logic [MAX_LIVES-1:0] mask_q, mask_d;
   logic                 freeze_q, freeze_d, vis_q, vis_d, death_q, death_d;
   logic                 respawn_q, respawn_d, go_q, go_d;
   logic                 clear, expire;
   logic [TW-1:0]        limit;

   assign limit = state_q == DYING ? TW'(DEATH_FRAMES) : TW'(RESPAWN_FRAMES);
   assign clear = state_d != state_q || !(state_q inside {DYING, RESPAWN});

   frame_timer #(.W(TW)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (clear),
      .tick   (startOfFrame),
      .limit  (limit),
      .expire (expire)
   );

   // next state, life bookkeeping and the registered output values
   always_comb begin
      lives_up = lives_q == LW'(MAX_LIVES) ? lives_q : lives_q + LW'(1);
      lives_dn = lives_q == '0 ? lives_q : lives_q - LW'(1);
      lives_b  = bonus_life ? lives_up : lives_q;
      state_d  = state_q;
      lives_d  = lives_q;
      case (state_q)
         IDLE:      state_d = playGame ? ALIVE : IDLE;
         ALIVE: begin
            lives_d = player_hit ? (bonus_life ? lives_q : lives_dn) : lives_b;
            state_d = !playGame ? IDLE : player_hit ? DYING : ALIVE;
         end
         DYING: begin
            lives_d = lives_b;
            state_d = !playGame ? IDLE : !expire ? DYING : lives_b == '0 ? GAME_OVER : RESPAWN;
         end
         RESPAWN: begin
            lives_d = lives_b;
            state_d = !playGame ? IDLE : expire ? ALIVE : RESPAWN;
         end
         GAME_OVER: state_d = playGame ? GAME_OVER : IDLE;
         default:   state_d = IDLE;
      endcase
      if (state_d == IDLE) lives_d = LW'(INIT_LIVES);
      mask_d    = MAX_LIVES'(lives_to_mask(32'(lives_d)));
      freeze_d  = state_d inside {IDLE, DYING, GAME_OVER};
      death_d   = state_d == DYING;
      go_d      = state_d == GAME_OVER;
      respawn_d = state_q == DYING && state_d == RESPAWN;
      vis_d     = state_d inside {ALIVE, DYING} ||
                  (state_d == RESPAWN && (state_q != RESPAWN || (vis_q ^ startOfFrame)));
   end

   // state and output registers
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q   <= IDLE;
         lives_q   <= LW'(INIT_LIVES);
         mask_q    <= MAX_LIVES'(lives_to_mask(INIT_LIVES));
         freeze_q  <= 1'b1;
         vis_q     <= 1'b0;
         death_q   <= 1'b0;
         respawn_q <= 1'b0;
         go_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         lives_q   <= lives_d;
         mask_q    <= mask_d;
         freeze_q  <= freeze_d;
         vis_q     <= vis_d;
         death_q   <= death_d;
         respawn_q <= respawn_d;
         go_q      <= go_d;
      end

   assign lives_count    = lives_q;
   assign lives_mask     = mask_q;
   assign freeze_game    = freeze_q;
   assign player_visible = vis_q;
   assign death_anim     = death_q;
   assign respawn        = respawn_q;
   assign game_over      = go_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// tb_player_life_ctrl: directed self-checking bench for the player life sequencer
module tb_player_life_ctrl;

   logic       clk = 1'b0;
   logic       reset, startOfFrame, playGame, player_hit, bonus_life;
   logic [2:0] lives_count;
   logic [4:0] lives_mask;
   logic       freeze_game, player_visible, death_anim, respawn, game_over;
   int         errors = 0;
   int         checks = 0;
   int         resp_cnt = 0;

   player_life_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .startOfFrame   (startOfFrame),
      .playGame       (playGame),
      .player_hit     (player_hit),
      .bonus_life     (bonus_life),
      .lives_count    (lives_count),
      .lives_mask     (lives_mask),
      .freeze_game    (freeze_game),
      .player_visible (player_visible),
      .death_anim     (death_anim),
      .respawn        (respawn),
      .game_over      (game_over)
   );

   always #5 clk = ~clk;

   // count every cycle the respawn pulse is high
   always @(posedge clk) if (respawn) resp_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic strobe();
      startOfFrame = 1'b1;
      cyc();
      startOfFrame = 1'b0;
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         strobe();
         cyc();
      end
   endtask

   task automatic hit();
      player_hit = 1'b1;
      cyc();
      player_hit = 1'b0;
   endtask

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; playGame = 1'b0; player_hit = 1'b0; bonus_life = 1'b0;
      cyc(); cyc();
      chk("rst_lives", 32'(lives_count), 3);
      chk("rst_mask", 32'(lives_mask), 32'b00111);
      chk("rst_freeze", 32'(freeze_game), 1);
      chk("rst_vis", 32'(player_visible), 0);
      chk("rst_death", 32'(death_anim), 0);
      chk("rst_go", 32'(game_over), 0);
      reset = 1'b0;
      cyc();
      playGame = 1'b1;
      cyc();
      chk("start_lives", 32'(lives_count), 3);
      chk("start_mask", 32'(lives_mask), 32'b00111);
      chk("start_freeze", 32'(freeze_game), 0);
      chk("start_vis", 32'(player_visible), 1);
      hit();
      chk("hit_lives", 32'(lives_count), 2);
      chk("hit_mask", 32'(lives_mask), 32'b00011);
      chk("hit_death", 32'(death_anim), 1);
      chk("hit_freeze", 32'(freeze_game), 1);
      frames(59);
      chk("dying59_death", 32'(death_anim), 1);
      chk("dying59_resp_cnt", 32'(resp_cnt), 0);
      strobe();
      chk("exp_respawn", 32'(respawn), 1);
      chk("exp_death", 32'(death_anim), 0);
      chk("exp_vis", 32'(player_visible), 1);
      chk("exp_freeze", 32'(freeze_game), 0);
      cyc();
      chk("respawn_once", 32'(respawn), 0);
      strobe();
      chk("blink1", 32'(player_visible), 0);
      strobe();
      chk("blink2", 32'(player_visible), 1);
      cyc();
      frames(27);
      chk("blink29", 32'(player_visible), 0);
      strobe();
      chk("alive_again_vis", 32'(player_visible), 1);
      chk("alive_again_freeze", 32'(freeze_game), 0);
      chk("resp_cnt_1", 32'(resp_cnt), 1);
      cyc();
      hit();
      chk("hit2_lives", 32'(lives_count), 1);
      frames(60); frames(30);
      hit();
      chk("hit3_lives", 32'(lives_count), 0);
      chk("hit3_mask", 32'(lives_mask), 0);
      frames(60);
      chk("go_flag", 32'(game_over), 1);
      chk("go_mask", 32'(lives_mask), 0);
      chk("go_freeze", 32'(freeze_game), 1);
      chk("go_vis", 32'(player_visible), 0);
      chk("go_death", 32'(death_anim), 0);
      chk("go_resp_cnt", 32'(resp_cnt), 2);
      bonus_life = 1'b1; player_hit = 1'b1;
      cyc();
      bonus_life = 1'b0; player_hit = 1'b0;
      chk("go_bonus_lives", 32'(lives_count), 0);
      chk("go_hold", 32'(game_over), 1);
      playGame = 1'b0;
      cyc();
      chk("idle_lives", 32'(lives_count), 3);
      chk("idle_go", 32'(game_over), 0);
      chk("idle_freeze", 32'(freeze_game), 1);
      playGame = 1'b1;
      cyc();
      bonus_life = 1'b1;
      cyc(); cyc(); cyc(); cyc();
      bonus_life = 1'b0;
      chk("sat_lives", 32'(lives_count), 5);
      chk("sat_mask", 32'(lives_mask), 32'b11111);
      player_hit = 1'b1; bonus_life = 1'b1;
      cyc();
      player_hit = 1'b0; bonus_life = 1'b0;
      chk("hitbonus_lives", 32'(lives_count), 5);
      chk("hitbonus_death", 32'(death_anim), 1);
      frames(20);
      playGame = 1'b0;
      cyc();
      chk("abort_death", 32'(death_anim), 0);
      chk("abort_lives", 32'(lives_count), 3);
      chk("abort_freeze", 32'(freeze_game), 1);
      chk("abort_respawn", 32'(respawn), 0);
      cyc(); cyc();
      chk("abort_resp_cnt", 32'(resp_cnt), 2);
      playGame = 1'b1;
      cyc();
      hit(); frames(60); frames(30);
      hit(); frames(60); frames(30);
      hit();
      chk("late_zero", 32'(lives_count), 0);
      frames(30);
      bonus_life = 1'b1;
      cyc();
      bonus_life = 1'b0;
      chk("late_bonus_lives", 32'(lives_count), 1);
      chk("late_bonus_death", 32'(death_anim), 1);
      frames(30);
      chk("late_go", 32'(game_over), 0);
      chk("late_death", 32'(death_anim), 0);
      chk("late_freeze", 32'(freeze_game), 0);
      chk("late_lives", 32'(lives_count), 1);
      chk("late_resp_cnt", 32'(resp_cnt), 5);
      hit();
      chk("invuln_lives", 32'(lives_count), 1);
      chk("invuln_death", 32'(death_anim), 0);
      frames(5);
      #3 reset = 1'b1;
      #1;
      chk("async_lives", 32'(lives_count), 3);
      chk("async_mask", 32'(lives_mask), 32'b00111);
      chk("async_freeze", 32'(freeze_game), 1);
      chk("async_vis", 32'(player_visible), 0);
      chk("async_respawn", 32'(respawn), 0);
      chk("async_go", 32'(game_over), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
